// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
// Asynchronous serial receiver with 16x oversampling. The line is
// synchronized, a falling edge on the idle line starts a frame, the start
// bit is re-checked at its midpoint and every following bit is sampled at
// its midpoint (16 ticks later). Frame format is latched at start detection
// so configuration changes mid-frame have no effect.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   rx           serial line, idle high, asynchronous to clk
//   rx_en        enables start detection (a frame in progress always completes)
//   baud[16:0]   clk cycles per 1/16-bit tick (0 and 1 both mean every clk)
//   length[3:0]  data bits per frame, clamped to 5..8
//   parity_en    parity bit present
//   parity_type  0 = even, 1 = odd
//   stop2        0 = one stop bit, 1 = two stop bits
//   rx_out[7:0]  last received data, right-aligned, unused MSBs zero
//   rx_done      one-clk pulse when a frame completes
//   busy         high whenever the receiver is not idle
//   rx_err       parity mismatch on the last frame
//   frame_err    a stop bit of the last frame was sampled low
module uart_rx_oversample (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   input  logic        rx_en,
   input  logic [16:0] baud,
   input  logic [3:0]  length,
   input  logic        parity_en,
   input  logic        parity_type,
   input  logic        stop2,
   output logic [7:0]  rx_out,
   output logic        rx_done,
   output logic        busy,
   output logic        rx_err,
   output logic        frame_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // Clamp requested data length into the supported 5..8 range.
   function automatic logic [3:0] clamp_len(input logic [3:0] len);
      logic [3:0] r;
      if (len < 4'd5) begin
         r = 4'd5;
      end else if (len > 4'd8) begin
         r = 4'd8;
      end else begin
         r = len;
      end
      return r;
   endfunction

   // Even parity of the data byte (unused MSBs are zero, so they do not count).
   function automatic logic parity_of(input logic [7:0] data);
      return ^data;
   endfunction

   state_t      state_q, state_d;
   logic        rx_meta_q;
   logic        rx_s_q;
   logic        rx_prev_q;
   logic [16:0] baud_cnt_q, baud_cnt_d;
   logic [3:0]  tick_cnt_q, tick_cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [3:0]  len_q, len_d;
   logic        par_en_q, par_en_d;
   logic        par_type_q, par_type_d;
   logic        stop2_q, stop2_d;
   logic        par_err_q, par_err_d;
   logic        frm_err_q, frm_err_d;
   logic [7:0]  rx_out_q, rx_out_d;
   logic        rx_done_q, rx_done_d;
   logic        rx_err_q, rx_err_d;
   logic        frame_err_q, frame_err_d;
   logic        busy_q, busy_d;

   logic [16:0] baud_max_s;
   logic        tick_s;
   logic        mid_s;
   logic        start_s;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   // Tick and edge qualifiers. A counter already past the limit (baud lowered
   // mid-count) ticks immediately instead of running round all 17 bits.
   always_comb begin
      if (baud < 17'd2) begin
         baud_max_s = 17'd0;
      end else begin
         baud_max_s = baud - 17'd1;
      end
      tick_s  = (baud_cnt_q >= baud_max_s);
      mid_s   = tick_s && (tick_cnt_q == 4'd15);
      start_s = rx_prev_q && !rx_s_q && rx_en;
   end

   // Next-state, datapath and output computation.
   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      len_d       = len_q;
      par_en_d    = par_en_q;
      par_type_d  = par_type_q;
      stop2_d     = stop2_q;
      par_err_d   = par_err_q;
      frm_err_d   = frm_err_q;
      rx_out_d    = rx_out_q;
      rx_err_d    = rx_err_q;
      frame_err_d = frame_err_q;
      rx_done_d   = 1'b0;

      // Counters are held at zero while idle, so a detected start begins
      // counting from a clean phase.
      if (state_q == S_IDLE) begin
         baud_cnt_d = 17'd0;
         tick_cnt_d = 4'd0;
      end else if (tick_s) begin
         baud_cnt_d = 17'd0;
         tick_cnt_d = tick_cnt_q + 4'd1;
      end else begin
         baud_cnt_d = baud_cnt_q + 17'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               state_d    = S_START;
               len_d      = clamp_len(length);
               par_en_d   = parity_en;
               par_type_d = parity_type;
               stop2_d    = stop2;
               bit_cnt_d  = 4'd0;
               shift_d    = 8'h00;
               par_err_d  = 1'b0;
               frm_err_d  = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            // Eighth tick is the middle of the start bit; a high line here
            // was a glitch and the receiver quietly returns to idle.
            if (tick_s && (tick_cnt_q == 4'd7)) begin
               tick_cnt_d = 4'd0;
               if (!rx_s_q) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (mid_s) begin
               shift_d[bit_cnt_q[2:0]] = rx_s_q;
               if (bit_cnt_q == (len_q - 4'd1)) begin
                  bit_cnt_d = 4'd0;
                  if (par_en_q) begin
                     state_d = S_PARITY;
                  end else begin
                     state_d = S_STOP;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_PARITY: begin
            if (mid_s) begin
               state_d = S_STOP;
               if (rx_s_q != (parity_of(shift_q) ^ par_type_q)) begin
                  par_err_d = 1'b1;
               end else begin
                  par_err_d = par_err_q;
               end
            end else begin
               state_d = S_PARITY;
            end
         end
         S_STOP: begin
            if (mid_s) begin
               if (!rx_s_q) begin
                  frm_err_d = 1'b1;
               end else begin
                  frm_err_d = frm_err_q;
               end
               if (stop2_q && (bit_cnt_q == 4'd0)) begin
                  bit_cnt_d = 4'd1;
               end else begin
                  // Last stop bit: publish data and both flags together.
                  state_d     = S_DONE;
                  rx_done_d   = 1'b1;
                  rx_out_d    = shift_q;
                  rx_err_d    = par_err_q;
                  frame_err_d = frm_err_q | ~rx_s_q;
               end
            end else begin
               state_d = S_STOP;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State, datapath and registered-output flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         baud_cnt_q  <= 17'd0;
         tick_cnt_q  <= 4'd0;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'h00;
         len_q       <= 4'd8;
         par_en_q    <= 1'b0;
         par_type_q  <= 1'b0;
         stop2_q     <= 1'b0;
         par_err_q   <= 1'b0;
         frm_err_q   <= 1'b0;
         rx_out_q    <= 8'h00;
         rx_done_q   <= 1'b0;
         rx_err_q    <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         len_q       <= len_d;
         par_en_q    <= par_en_d;
         par_type_q  <= par_type_d;
         stop2_q     <= stop2_d;
         par_err_q   <= par_err_d;
         frm_err_q   <= frm_err_d;
         rx_out_q    <= rx_out_d;
         rx_done_q   <= rx_done_d;
         rx_err_q    <= rx_err_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   assign rx_out    = rx_out_q;
   assign rx_done   = rx_done_q;
   assign busy      = busy_q;
   assign rx_err    = rx_err_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;

   logic        clk;
   logic        rst;
   logic        rx;
   logic        rx_en;
   logic [16:0] baud;
   logic [3:0]  length;
   logic        parity_en;
   logic        parity_type;
   logic        stop2;
   logic [7:0]  rx_out;
   logic        rx_done;
   logic        busy;
   logic        rx_err;
   logic        frame_err;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   done_cnt = 0;
   int   pushed = 0;

   uart_rx_oversample dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .rx_en      (rx_en),
      .baud       (baud),
      .length     (length),
      .parity_en  (parity_en),
      .parity_type(parity_type),
      .stop2      (stop2),
      .rx_out     (rx_out),
      .rx_done    (rx_done),
      .busy       (busy),
      .rx_err     (rx_err),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
      exp_t e;
      e.data = d;
      e.perr = pe;
      e.ferr = fe;
      exp_q.push_back(e);
      pushed++;
   endtask

   // Scoreboard monitor: every rx_done pulse consumes one expected frame.
   always @(negedge clk) begin
      exp_t e;
      if (rst && rx_done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: rx_out=0x%0h with no frame expected", rx_out);
         end else begin
            e = exp_q.pop_front();
            check("rx_out", rx_out, e.data);
            check("rx_err", rx_err, e.perr);
            check("frame_err", frame_err, e.ferr);
         end
      end
   end

   task automatic drive_bits(input logic [11:0] v, input int n, input int cpb);
      for (int i = 0; i < n; i++) begin
         rx = v[i];
         repeat (cpb) @(negedge clk);
      end
   endtask

   // Builds start/data/parity/stop bits LSB first; second stop bit value given.
   task automatic send(input logic [7:0] d, input int nbits, input bit pen,
                       input bit pbit, input int nstop, input bit s2, input int cpb);
      logic [11:0] v;
      int k;
      v = 12'hFFF;
      v[0] = 1'b0;
      k = 1;
      for (int i = 0; i < nbits; i++) begin
         v[k] = d[i];
         k++;
      end
      if (pen) begin
         v[k] = pbit;
         k++;
      end
      v[k] = 1'b1;
      k++;
      if (nstop == 2) begin
         v[k] = s2;
         k++;
      end
      drive_bits(v, k, cpb);
      rx = 1'b1;
      repeat (2 * cpb) @(negedge clk);
   endtask

   task automatic config_frame(input logic [16:0] b, input logic [3:0] len,
                               input logic pen, input logic pt, input logic s2);
      baud        = b;
      length      = len;
      parity_en   = pen;
      parity_type = pt;
      stop2       = s2;
   endtask

   initial begin
      int before_done;
      logic [7:0] before_out;
      rst = 1'b0;
      rx = 1'b1;
      rx_en = 1'b1;
      config_frame(17'd1, 4'd8, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("reset_rx_out", rx_out, 8'h00);
      check("reset_rx_done", rx_done, 1'b0);
      check("reset_rx_err", rx_err, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_busy", busy, 1'b0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // 8N1 0xA5 at baud=1
      expect_frame(8'hA5, 1'b0, 1'b0);
      send(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 16);
      check("busy_after_done", busy, 1'b0);
      check("single_done", done_cnt, 1);

      // 7E1 0x35: parity 0 correct, parity 1 wrong
      config_frame(17'd1, 4'd7, 1'b1, 1'b0, 1'b0);
      expect_frame(8'h35, 1'b0, 1'b0);
      send(8'h35, 7, 1'b1, 1'b0, 1, 1'b1, 16);
      expect_frame(8'h35, 1'b1, 1'b0);
      send(8'h35, 7, 1'b1, 1'b1, 1, 1'b1, 16);

      // 8N2 0x5A, second stop bit low
      config_frame(17'd1, 4'd8, 1'b0, 1'b0, 1'b1);
      before_done = done_cnt;
      expect_frame(8'h5A, 1'b0, 1'b1);
      send(8'h5A, 8, 1'b0, 1'b0, 2, 1'b0, 16);
      check("frame_err_single_done", done_cnt - before_done, 1);

      // 8N1 0xC3 with configuration and rx_en changed mid-frame
      config_frame(17'd1, 4'd8, 1'b0, 1'b0, 1'b0);
      expect_frame(8'hC3, 1'b0, 1'b0);
      fork
         send(8'hC3, 8, 1'b0, 1'b0, 1, 1'b1, 16);
         begin
            repeat (40) @(negedge clk);
            config_frame(17'd1, 4'd5, 1'b1, 1'b1, 1'b1);
            rx_en = 1'b0;
         end
      join
      rx_en = 1'b1;
      config_frame(17'd1, 4'd8, 1'b0, 1'b0, 1'b0);

      // False start: line low for 4 clk only
      before_done = done_cnt;
      before_out = rx_out;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      check("false_start_busy_high", busy, 1'b1);
      repeat (8) @(negedge clk);
      check("false_start_busy_low", busy, 1'b0);
      repeat (20) @(negedge clk);
      check("false_start_no_done", done_cnt - before_done, 0);
      check("false_start_rx_out", rx_out, before_out);

      // Reset during data bit 3 of 0x3C (start + bits 0..2, then half of bit 3)
      drive_bits(12'b1111_0111_1000, 4, 16);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      before_done = done_cnt;
      rst = 1'b0;
      #1;
      check("midreset_rx_out", rx_out, 8'h00);
      check("midreset_rx_done", rx_done, 1'b0);
      check("midreset_busy", busy, 1'b0);
      check("midreset_rx_err", rx_err, 1'b0);
      check("midreset_frame_err", frame_err, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check("midreset_no_done", done_cnt - before_done, 0);
      expect_frame(8'h3C, 1'b0, 1'b0);
      send(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 16);

      // baud=4, 5O1: 0x1F (parity bit 0), then length=3 behaving as 5 with 0x0A (parity bit 1)
      config_frame(17'd4, 4'd5, 1'b1, 1'b1, 1'b0);
      expect_frame(8'h1F, 1'b0, 1'b0);
      send(8'h1F, 5, 1'b1, 1'b0, 1, 1'b1, 64);
      config_frame(17'd4, 4'd3, 1'b1, 1'b1, 1'b0);
      expect_frame(8'h0A, 1'b0, 1'b0);
      send(8'h0A, 5, 1'b1, 1'b1, 1, 1'b1, 64);

      // Drain: every expected frame must have been seen within a bounded wait
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
         @(negedge clk);
      end
      check("frames_pending", exp_q.size(), 0);
      check("total_done", done_cnt, pushed);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: rx  input  1  serial line, idle high, asynchronous to clk.
REQ-004 SHALL have port: rx_en  input  1  receiver enable; start detection only while high.
REQ-005 SHALL have port: baud  input  17  clk cycles per 1/16-bit tick; values 0 and 1 both mean one tick per clk.
REQ-006 SHALL have port: length  input  4  data bits per frame; below 5 treated as 5, above 8 treated as 8.
REQ-007 SHALL have ports: parity_en  input  1  parity bit present; parity_type  input  1  0 = even, 1 = odd.
REQ-008 SHALL have port: stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 SHALL have port: rx_out  output  8  last received data, right-aligned, unused MSBs 0.
REQ-010 SHALL have ports: rx_done  output  1  one-clk frame-complete pulse; busy  output  1  high in every state except IDLE.
REQ-011 SHALL have ports: rx_err  output  1  parity mismatch; frame_err  output  1  stop bit sampled low.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rx_s.
REQ-013 SHALL generate a tick when the baud counter reaches max(baud,1)-1, then wrap to 0; the counter SHALL be cleared on start detection.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-015 IDLE: rx_s high on previous clk and low on current clk with rx_en=1 -> START; latch length, parity_en, parity_type, stop2; clear tick and bit counters.
REQ-016 START: at the 8th tick (mid start bit) rx_s=0 -> DATA; rx_s=1 -> IDLE, no rx_done, no flag change.
REQ-017 DATA: sample every 16th tick, LSB first; after the latched length bits -> PARITY if parity_en, else STOP.
REQ-018 PARITY: sample after 16 ticks; expected = XOR of data bits (even) or its inverse (odd); mismatch sets internal parity error.
REQ-019 STOP: sample each stop bit after 16 ticks (1 or 2 per latched stop2); any low sample sets internal frame error; no early exit, all stop bits are sampled.
REQ-020 DONE: lasts exactly one clk; rx_done=1; rx_out, rx_err, frame_err updated together; next state IDLE.
REQ-021 rx_out, rx_err, frame_err SHALL hold until the next DONE; rx_out SHALL update even when either error flag is set.
REQ-022 Configuration input changes mid-frame SHALL be ignored; rx_en deassertion mid-frame SHALL NOT abort the frame.
REQ-023 After a frame-error frame, a new start SHALL only be detected after rx_s returns high (falling-edge rule, REQ-015).
REQ-024 rx_done latency SHALL be one clk after the tick that samples the last stop bit.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, clear all counters, rx_out=0x00, rx_done=0, rx_err=0, frame_err=0, busy=0, and set synchronizer flops to 1.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no rx_done pulse; the first clean frame after release SHALL be received correctly.

Verification
REQ-027 baud=1, length=8, no parity, stop2=0; drive 0xA5 at 16 clk/bit -> rx_out=0xA5, one rx_done pulse, rx_err=0, frame_err=0, busy low after DONE.
REQ-028 length=7, parity_en=1, parity_type=0; send 0x35 with parity 0 -> rx_out=0x35, rx_err=0; resend with parity 1 -> rx_out=0x35, rx_err=1.
REQ-029 stop2=1, 8N2, 0x5A with second stop bit driven low -> rx_out=0x5A, frame_err=1, rx_done pulses once.
REQ-030 baud=1; rx low for 4 clk then high -> no rx_done, busy returns to 0 by clk 12 after the fall, outputs unchanged.
REQ-031 rst pulsed low during DATA bit 3 -> all outputs 0 at once; next 0x3C frame -> rx_out=0x3C, no errors.
REQ-032 baud=4 (64 clk/bit), length=5, parity_en=1, parity_type=1, 0x1F -> rx_out=0x1F, rx_err=0; length=3 set behaves as length=5.
